// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM time base.
// CONTADOR_CENTRADO_EN selects center-aligned counting in contador_pwm.
package pwm_pkg;
  localparam int ANCHO_PWM       = 10;
  localparam int PERIODO_RST_DEF = 1023;

  typedef logic [ANCHO_PWM-1:0] pwm_val_t;

  // Ramp direction, only meaningful for center-aligned counting.
  typedef enum logic {SUBE, BAJA} dir_t;
endpackage

// File: rtl/prescalador_pwm.sv
// Clock prescaler: tick is high one clk cycle out of every DIV_PRESC while enabled.
module prescalador_pwm #(
  parameter int DIV_PRESC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilitar,
  output logic tick
);
  localparam int PW = (DIV_PRESC > 1) ? $clog2(DIV_PRESC) : 1;
  localparam logic [PW-1:0] ULTIMO = PW'(DIV_PRESC - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      presc <= '0;
    else if (habilitar)
      presc <= (presc == ULTIMO) ? '0 : presc + PW'(1);
  end

  // Gated by habilitar so a held prescaler never advances the counter.
  assign tick = habilitar && (presc == ULTIMO);
endmodule

// File: rtl/contador_pwm.sv
// PWM time base: prescaled ramp, shadowed period/duty loaded via valid/ready.
// Define CONTADOR_CENTRADO_EN for center-aligned up/down counting.
module contador_pwm
  import pwm_pkg::*;
#(
  parameter int ANCHO       = ANCHO_PWM,
  parameter int DIV_PRESC   = 4,
  parameter int PERIODO_RST = PERIODO_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             habilitar,
  input  logic [ANCHO-1:0] periodo_in,
  input  logic [ANCHO-1:0] cuenta_in,
  input  logic             carga_valida,
  output logic             carga_lista,
  output logic [ANCHO-1:0] contador_clk,
  output logic [ANCHO-1:0] cuenta_max,
  output logic             inicio_periodo
);
  logic             tick;
  logic [ANCHO-1:0] periodo_act, pend_periodo, pend_cuenta, cnt_sig;
  logic             pendiente, fin_periodo, transfer;

  prescalador_pwm #(.DIV_PRESC(DIV_PRESC)) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .habilitar (habilitar),
    .tick      (tick)
  );

  assign transfer = carga_valida && carga_lista;

`ifdef CONTADOR_CENTRADO_EN
  dir_t dir, dir_sig;

  always_comb begin
    cnt_sig = contador_clk;
    dir_sig = dir;
    if (periodo_act == '0) begin
      cnt_sig = '0;
      dir_sig = SUBE;
    end else if (dir == SUBE) begin
      if (contador_clk >= periodo_act) begin
        cnt_sig = contador_clk - ANCHO'(1);
        dir_sig = BAJA;
      end else begin
        cnt_sig = contador_clk + ANCHO'(1);
      end
    end else if (contador_clk == '0) begin
      cnt_sig = ANCHO'(1);
      dir_sig = SUBE;
    end else begin
      cnt_sig = contador_clk - ANCHO'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dir <= SUBE;
    else if (!habilitar && pendiente)
      dir <= SUBE;
    else if (tick)
      dir <= dir_sig;
  end
`else
  always_comb cnt_sig = (contador_clk == periodo_act) ? '0 : contador_clk + ANCHO'(1);
`endif

  // Period boundary: the tick that lands the counter on 0 (every tick when period is 0).
  assign fin_periodo = tick && (cnt_sig == '0) &&
                       ((contador_clk != '0) || (periodo_act == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_clk   <= '0;
      periodo_act    <= ANCHO'(PERIODO_RST);
      cuenta_max     <= '0;
      pend_periodo   <= '0;
      pend_cuenta    <= '0;
      pendiente      <= 1'b0;
      carga_lista    <= 1'b1;
      inicio_periodo <= 1'b0;
    end else begin
      inicio_periodo <= fin_periodo;
      if (tick)
        contador_clk <= cnt_sig;
      // While stopped there is no boundary to wait for, so apply now and restart at 0.
      if (pendiente && (fin_periodo || !habilitar)) begin
        periodo_act <= pend_periodo;
        cuenta_max  <= pend_cuenta;
        pendiente   <= 1'b0;
        if (!habilitar)
          contador_clk <= '0;
      end
      if (transfer) begin
        pend_periodo <= periodo_in;
        pend_cuenta  <= cuenta_in;
        pendiente    <= 1'b1;
        carga_lista  <= 1'b0;
      end else if (!carga_lista && !pendiente) begin
        carga_lista <= 1'b1;
      end
    end
  end
endmodule

// File: doc/contador_pwm.md
Name: contador_pwm

Overview:
- Time-base stage directly upstream of the PWM comparator. Produces the 10-bit `contador_clk` ramp and the `cuenta_max` threshold that the comparator compares.
- A prescaler divides `clk` to set the PWM frequency.
- Period and duty values from the current decoder pass through a valid/ready handshake into shadow registers. They are applied only at a period boundary, so the PWM output never glitches mid-period.

Parameters:
- ANCHO, 10, width of counter, period and duty buses (matches comparator).
- DIV_PRESC, 4, clk cycles per counter tick; legal values are 1..1024.
- PERIODO_RST, 1023, period register value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- habilitar  in  1  run enable for prescaler and counter.
- periodo_in  in  ANCHO  requested period (counter top value).
- cuenta_in  in  ANCHO  requested duty threshold.
- carga_valida  in  1  request to load `periodo_in`/`cuenta_in`.
- carga_lista  out  1  ready; a transfer occurs when `carga_valida` and `carga_lista` are both high.
- contador_clk  out  ANCHO  ramp to comparator.
- cuenta_max  out  ANCHO  active duty threshold to comparator.
- inicio_periodo  out  1  one-cycle pulse at each period start.

Behaviour:
- Reset values (async on `rst_n`=0):
  - prescaler 0, `contador_clk` 0, `periodo_act` PERIODO_RST, `cuenta_max` 0 (PWM low).
  - pending flag 0, `carga_lista` 1, `inicio_periodo` 0.
- Release is synchronous to clk; no `inicio_periodo` pulse on reset exit.
- Prescaler:
  - While `habilitar`=1, counts 0..DIV_PRESC-1 and wraps.
  - `tick` is high in the cycle where prescaler = DIV_PRESC-1.
  - DIV_PRESC=1 gives `tick` every cycle.
- Counter (sawtooth):
  - On `tick`: if `contador_clk` = `periodo_act`, next value is 0; otherwise +1.
  - Period is therefore (`periodo_act`+1) ticks.
- `inicio_periodo`: registered; high for exactly the one clk cycle in which `contador_clk` first equals 0 after a wrap.
- `periodo_act`=0: counter stays at 0 and `inicio_periodo` pulses once per tick.
- Handshake:
  - On transfer, capture `periodo_in`/`cuenta_in` into pending registers, set pending, and drop `carga_lista` from the next cycle.
  - `carga_valida` while `carga_lista`=0 is ignored; the data is not captured.
- Apply:
  - On the tick that wraps the counter to 0 with pending=1: `periodo_act` and `cuenta_max` take the pending values in that same clock edge, and pending clears.
  - `carga_lista` returns to 1 the following cycle.
  - A transfer in the same cycle as a wrap is not applied at that wrap; it waits for the next wrap.
- Disabled (`habilitar`=0):
  - Prescaler, counter and `inicio_periodo` hold (`inicio_periodo` = 0).
  - Any pending load is applied on the next clk edge, and `contador_clk` is forced to 0 at that edge.
- Duty ≥ period+1 is legal and gives 100% duty downstream. Duty 0 gives 0%. No clamping.
- Reset mid-period or mid-handshake discards pending data and returns every output to its reset value.

Optional Feature:
- CONTADOR_CENTRADO_EN defined: center-aligned up/down counting.
  - Counter rises 0→`periodo_act`, then falls to 0; direction flips at both ends.
  - Each endpoint value is held for one tick only, giving a period of 2·`periodo_act` ticks.
  - `inicio_periodo` and shadow apply occur only at the 0 endpoint.
  - The direction register resets to "up".
  - `periodo_act`=0 behaves as in sawtooth mode.
- Undefined: sawtooth behaviour as above; no direction register is synthesized.

Decomposition:
- Shared package `pwm_pkg`: constant ANCHO_PWM=10; PERIODO_RST default; typedef `pwm_val_t` (logic [ANCHO_PWM-1:0]); direction enum {SUBE, BAJA}, used only when CONTADOR_CENTRADO_EN is defined.
- One sub-module, `prescalador_pwm` (params DIV_PRESC; ports `clk`, `rst_n`, `habilitar`, `tick`), instantiated once.
- Counter, shadow and handshake logic stay in `contador_pwm`.

Test Plan:
- Reset, then `rst_n`=1 with `habilitar`=0 → `contador_clk`=0, `cuenta_max`=0, `carga_lista`=1, `inicio_periodo`=0, all held steady.
- DIV_PRESC=2, `habilitar`=0, load `periodo_in`=3 / `cuenta_in`=2, then `habilitar`=1 → `contador_clk` sequence 0,0,1,1,2,2,3,3,0…; `inicio_periodo` high once every 8 clk; `cuenta_max`=2.
- While running with period 3, load `cuenta_in`=1 at `contador_clk`=1 → `carga_lista` low next cycle; `cuenta_max` stays 2 until the wrap to 0, then becomes 1; `carga_lista` high one cycle later.
- Transfer issued in the exact wrap cycle → values not applied at that wrap; applied at the following wrap.
- `periodo_in`=0, DIV_PRESC=1 → `contador_clk` constant 0, `inicio_periodo` high every cycle. `cuenta_in`=5 with period 3 → `cuenta_max`=5 (no clamp).
- With CONTADOR_CENTRADO_EN, period 3, DIV_PRESC=1 → sequence 0,1,2,3,2,1,0,1…; `inicio_periodo` only at 0. Async reset asserted at `contador_clk`=2 → all outputs at reset values immediately.
